// File: rtl/ff_sched_if.sv
// -----------------------------------------------------------------------------
// ff_sched_if
// Bundles the request, fitness-unit and response channels of ff_sched.
//
// Handshake semantics (both req_* and rsp_*): a transfer happens on a rising
// clock edge where valid and ready are both 1. A source holds valid and its
// payload stable until the transfer. The scheduler's req_ready is combinational
// from req_valid; rsp_valid never depends on rsp_ready.
//
// Optional best-tracking signals exist only when FF_SCHED_BEST_EN is defined.
//
// Modports:
//   master : the scheduler side (drives req_ready, ff_*, rsp_*, best_*)
//   slave  : the environment side (requesters, fitness unit, response sink)
// -----------------------------------------------------------------------------
interface ff_sched_if #(
  parameter int INPUT_WIDTH = 8,
  parameter int NUM_REQ     = 4
);
  localparam int OUTPUT_WIDTH = (INPUT_WIDTH + 1) * 3;
  localparam int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_chrom;
  logic [NUM_REQ-1:0]             req_ready;
  logic [INPUT_WIDTH-1:0]         ff_chrom;
  logic                           ff_enable;
  logic [OUTPUT_WIDTH-1:0]        ff_fitness;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_WIDTH-1:0]            rsp_id;
  logic [INPUT_WIDTH-1:0]         rsp_chrom;
  logic [OUTPUT_WIDTH-1:0]        rsp_fitness;
`ifdef FF_SCHED_BEST_EN
  logic                           best_clr;
  logic                           best_valid;
  logic [OUTPUT_WIDTH-1:0]        best_fitness;
  logic [INPUT_WIDTH-1:0]         best_chrom;
  logic [ID_WIDTH-1:0]            best_id;

  modport master (
    input  req_valid, req_chrom, ff_fitness, rsp_ready, best_clr,
    output req_ready, ff_chrom, ff_enable, rsp_valid, rsp_id, rsp_chrom,
           rsp_fitness, best_valid, best_fitness, best_chrom, best_id
  );
  modport slave (
    output req_valid, req_chrom, ff_fitness, rsp_ready, best_clr,
    input  req_ready, ff_chrom, ff_enable, rsp_valid, rsp_id, rsp_chrom,
           rsp_fitness, best_valid, best_fitness, best_chrom, best_id
  );
`else
  modport master (
    input  req_valid, req_chrom, ff_fitness, rsp_ready,
    output req_ready, ff_chrom, ff_enable, rsp_valid, rsp_id, rsp_chrom,
           rsp_fitness
  );
  modport slave (
    output req_valid, req_chrom, ff_fitness, rsp_ready,
    input  req_ready, ff_chrom, ff_enable, rsp_valid, rsp_id, rsp_chrom,
           rsp_fitness
  );
`endif
endinterface

// File: rtl/ff_sched.sv
// -----------------------------------------------------------------------------
// ff_sched
// Round-robin scheduler sharing one single-cycle, registered, enable-gated
// fitness unit among NUM_REQ chromosome requesters. One chromosome per
// transaction: IDLE (grant) -> ISSUE (enable) -> CAPTURE -> RESP.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         ff_sched_if.master: request, fitness-unit and response channels
//   o_dbg_state current FSM state (0 IDLE, 1 ISSUE, 2 CAPTURE, 3 RESP)
//
// Optional feature macro: FF_SCHED_BEST_EN -- tracks the best (strictly
// greatest unsigned) fitness returned so far, clearable by bus.best_clr.
// -----------------------------------------------------------------------------
module ff_sched #(
  parameter int INPUT_WIDTH = 8,
  parameter int NUM_REQ     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  ff_sched_if.master bus,
  output logic [1:0] o_dbg_state
);
  localparam int OUTPUT_WIDTH = (INPUT_WIDTH + 1) * 3;
  localparam int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  logic [1:0]              r_state;
  logic [ID_WIDTH-1:0]     r_ptr;
  logic [INPUT_WIDTH-1:0]  r_ff_chrom;
  logic [ID_WIDTH-1:0]     r_rsp_id;
  logic [INPUT_WIDTH-1:0]  r_rsp_chrom;
  logic [OUTPUT_WIDTH-1:0] r_rsp_fitness;

  logic [NUM_REQ-1:0]      w_gnt;
  logic                    w_found;
  logic [ID_WIDTH-1:0]     w_gnt_idx;
  logic [INPUT_WIDTH-1:0]  w_gnt_chrom;
  logic [ID_WIDTH-1:0]     w_ptr_nxt;
  logic                    w_rsp_hs;

  // Rotating priority without a variable index: first pass looks at
  // requesters at or above the pointer, second pass wraps to those below it.
  // Gating with rst_n keeps req_ready low for the whole reset assertion.
  always_comb begin
    w_gnt       = '0;
    w_found     = 1'b0;
    w_gnt_idx   = '0;
    w_gnt_chrom = '0;
    if (rst_n && (r_state == ST_IDLE)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && bus.req_valid[i] && (ID_WIDTH'(i) >= r_ptr)) begin
          w_found     = 1'b1;
          w_gnt[i]    = 1'b1;
          w_gnt_idx   = ID_WIDTH'(i);
          w_gnt_chrom = bus.req_chrom[i*INPUT_WIDTH +: INPUT_WIDTH];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && bus.req_valid[i] && (ID_WIDTH'(i) < r_ptr)) begin
          w_found     = 1'b1;
          w_gnt[i]    = 1'b1;
          w_gnt_idx   = ID_WIDTH'(i);
          w_gnt_chrom = bus.req_chrom[i*INPUT_WIDTH +: INPUT_WIDTH];
        end
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NUM_REQ-1 (stays 0 when
  // NUM_REQ is 1).
  always_comb begin
    w_ptr_nxt = '0;
    if (w_gnt_idx != ID_WIDTH'(NUM_REQ - 1)) begin
      w_ptr_nxt = w_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_ff_chrom    <= '0;
      r_rsp_id      <= '0;
      r_rsp_chrom   <= '0;
      r_rsp_fitness <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_ff_chrom <= w_gnt_chrom;
            r_rsp_id   <= w_gnt_idx;
            r_ptr      <= w_ptr_nxt;
            r_state    <= ST_ISSUE;
          end
        end
        // The unit registers its result at the end of ISSUE, so the value
        // on ff_fitness during CAPTURE belongs to this transaction.
        ST_ISSUE: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_rsp_fitness <= bus.ff_fitness;
          r_rsp_chrom   <= r_ff_chrom;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_rsp_hs        = (r_state == ST_RESP) && bus.rsp_ready;

  assign bus.req_ready   = w_gnt;
  assign bus.ff_chrom    = r_ff_chrom;
  assign bus.ff_enable   = (r_state == ST_ISSUE);
  assign bus.rsp_valid   = (r_state == ST_RESP);
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_chrom   = r_rsp_chrom;
  assign bus.rsp_fitness = r_rsp_fitness;
  assign o_dbg_state     = r_state;

`ifdef FF_SCHED_BEST_EN
  logic                    r_best_valid;
  logic [OUTPUT_WIDTH-1:0] r_best_fitness;
  logic [INPUT_WIDTH-1:0]  r_best_chrom;
  logic [ID_WIDTH-1:0]     r_best_id;

  // Clear wins over a same-cycle update; ties keep the older entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_valid   <= 1'b0;
      r_best_fitness <= '0;
      r_best_chrom   <= '0;
      r_best_id      <= '0;
    end else if (bus.best_clr) begin
      r_best_valid <= 1'b0;
    end else if (w_rsp_hs && (!r_best_valid || (r_rsp_fitness > r_best_fitness))) begin
      r_best_valid   <= 1'b1;
      r_best_fitness <= r_rsp_fitness;
      r_best_chrom   <= r_rsp_chrom;
      r_best_id      <= r_rsp_id;
    end
  end

  assign bus.best_valid   = r_best_valid;
  assign bus.best_fitness = r_best_fitness;
  assign bus.best_chrom   = r_best_chrom;
  assign bus.best_id      = r_best_id;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_rsp_hs;
`endif
endmodule

// File: doc/ff_sched.md
Name: ff_sched

Overview:
- Round-robin scheduler that shares one single-cycle fitness unit (ff_1v3d, registered output, enable-gated) among NUM_REQ chromosome requesters.
- Accepts one chromosome per transaction and sequences the unit's enable.
- Captures the fitness result and returns it with the requester ID over a valid/ready response channel.
- Sits between the GA population/selection logic and the fitness datapath.

Parameters:
- INPUT_WIDTH, 8, chromosome width; must match the fitness unit.
- NUM_REQ, 4, number of requesters; at least 1.
- OUTPUT_WIDTH, (INPUT_WIDTH+1)*3, fitness width. Local parameter, not overridable.
- ID_WIDTH, max(1, $clog2(NUM_REQ)), requester ID width. Local parameter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_chrom  input  NUM_REQ*INPUT_WIDTH  packed chromosomes; requester i occupies bits [i*INPUT_WIDTH +: INPUT_WIDTH]
- req_ready  output  NUM_REQ  one-hot grant/accept
- ff_chrom  output  INPUT_WIDTH  to fitness unit chrom
- ff_enable  output  1  to fitness unit enable
- ff_fitness  input  OUTPUT_WIDTH  from fitness unit fitness
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  ID_WIDTH  requester index of the response
- rsp_chrom  output  INPUT_WIDTH  evaluated chromosome
- rsp_fitness  output  OUTPUT_WIDTH  captured fitness

Behaviour:
- Reset (async assert, sync deassert is external):
  - State IDLE, RR pointer 0.
  - ff_enable=0, ff_chrom=0, rsp_valid=0, rsp_id=0, rsp_chrom=0, rsp_fitness=0.
  - req_ready=0 while rst_n low.
  - Reset mid-transaction abandons it silently; no response is produced.
- Arbitration:
  - Active only in IDLE. Scan from the pointer upward with wrap; the first i with req_valid[i]=1 gets req_ready[i]=1 in the same cycle (combinational).
  - All other req_ready bits are 0, and all are 0 outside IDLE.
  - Handshake at valid&ready: latch the chrom into ff_chrom, latch i into rsp_id, set pointer=(i+1) mod NUM_REQ, then go to ISSUE.
- Request rules: a requester holds req_valid and req_chrom stable until accepted. Withdrawing before grant is tolerated; it is simply not granted.
- FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE:
  - ISSUE, 1 cycle: ff_enable=1 and ff_chrom stable. The unit registers the fitness at the end of this cycle.
  - CAPTURE, 1 cycle: ff_enable=0. Register ff_fitness into rsp_fitness and ff_chrom into rsp_chrom.
  - RESP: rsp_valid=1 with rsp_id, rsp_chrom and rsp_fitness stable until rsp_ready=1. On that edge, clear rsp_valid and go to IDLE.
- Latency: handshake in cycle 0; rsp_valid=1 in cycle 3. Best-case throughput is 1 evaluation per 4 cycles.
- ff_enable is high only in ISSUE and is never asserted twice per transaction.
- rsp_ready outside RESP is ignored.
- There is no new grant in the RESP/IDLE return cycle; IDLE arbitration starts the cycle after the response handshake.
- With NUM_REQ=1 the pointer stays 0 and rsp_id=0.
- ff_chrom holds its last value between transactions.

Optional Feature:
- Macro: FF_SCHED_BEST_EN
- Defined:
  - Adds outputs best_valid(1), best_fitness(OUTPUT_WIDTH), best_chrom(INPUT_WIDTH) and best_id(ID_WIDTH).
  - Adds input best_clr(1), synchronous, active-high.
  - On each response handshake, update the best registers if best_valid=0 or rsp_fitness > best_fitness, using strict unsigned greater-than. Ties keep the older entry.
  - best_clr clears best_valid and has priority over a same-cycle update.
  - All best registers reset to 0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Single request, fitness unit is ff_1v3d: requester 2 sends chrom=20 -> req_ready[2] in cycle 0, ff_enable only in cycle 1, rsp_valid in cycle 3 with rsp_id=2, rsp_chrom=20, rsp_fitness=2500.
- All 4 requesters valid continuously (chroms 0, 10, 20, 30), rsp_ready=1 -> grants in order 0,1,2,3,0; fitness 500, 0, 2500, 14000; 4 cycles between grants.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, ff_enable stays 0, no req_ready asserted; rsp_ready=1 -> IDLE next cycle.
- Pointer wrap: after a grant to requester 3, only requesters 0 and 3 valid -> requester 0 granted next.
- Reset asserted during CAPTURE -> rsp_valid, ff_enable and req_ready go 0 immediately; pointer 0; no response after release.
- FF_SCHED_BEST_EN: responses with fitness 500, 2500, 2500, 0 -> best_fitness=2500 holding the first 2500's id; best_clr -> best_valid=0.
